// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the IF-stage signals: control from later stages, the instruction
//   ROM port and the IF/ID pipeline register outputs.
//
//   Handshake: there is no ready signal towards fetch. 'stall' is the
//   back-pressure from decode. While it is high, the IF/ID entry (if_valid and
//   its payload) is held and must not be considered consumed. An entry with
//   if_valid high is consumed on every rising edge where stall is low.
//
//   master : the fetch stage (drives rom_address and if_*)
//   slave  : the surrounding pipeline / ROM (drives control and rom_data)
// ----------------------------------------------------------------------------
interface instruction_fetch_if;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;
    logic        if_misaligned;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, rom_data,
        output rom_address, if_valid, if_pc, if_pc_plus4, if_instruction,
               if_misaligned
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, rom_data,
        input  rom_address, if_valid, if_pc, if_pc_plus4, if_instruction,
               if_misaligned
    );
endinterface

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the single-issue RV32 pipeline. Owns the PC, drives the
//   combinational instruction ROM address and fills the IF/ID register.
//
//   Ports:
//     clk          rising-edge clock
//     reset        synchronous, active-high reset
//     bus          instruction_fetch_if.master (control, ROM port, IF/ID out)
//     debug_state  current FSM state (0 = RUN, 1 = HALT)
//
//   Parameters:
//     RESET_PC     PC loaded on reset
//     NOP_INSTR    instruction placed in bubbles (addi x0,x0,0)
//
//   Optional feature, macro INSTRUCTION_FETCH_MISALIGN_TRAP_EN:
//     a redirect to an odd address produces one trap entry (if_misaligned)
//     and parks the stage in HALT until an aligned redirect or reset.
//     Without it, redirect_pc[0] is dropped and if_misaligned is 0.
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        bus,
    output logic                       debug_state
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state, state_next;

    logic [31:0] pc, pc_next;
    logic [31:0] pc_plus4;

    logic        entry_valid, entry_valid_next;
    logic [31:0] entry_pc, entry_pc_next;
    logic [31:0] entry_pc_plus4, entry_pc_plus4_next;
    logic [31:0] entry_instr, entry_instr_next;

`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
    logic        entry_misaligned, entry_misaligned_next;
    // Set while the trap entry for the halted PC has not yet been delivered.
    logic        trap_pending, trap_pending_next;
`endif

    assign pc_plus4 = pc + 32'd4;  // modulo 2^32, wraps silently

    // Next-state / next-register logic. Priority: redirect > (HALT) > flush
    // > stall > normal fetch.
    always_comb begin
        state_next          = state;
        pc_next             = pc;
        entry_valid_next    = entry_valid;
        entry_pc_next       = entry_pc;
        entry_pc_plus4_next = entry_pc_plus4;
        entry_instr_next    = entry_instr;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
        entry_misaligned_next = entry_misaligned;
        trap_pending_next     = trap_pending;
`endif

        if (bus.redirect_valid) begin
            // Redirect wins over stall so a taken branch is never lost.
            entry_valid_next = 1'b0;
            entry_instr_next = NOP_INSTR;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            entry_misaligned_next = 1'b0;
            pc_next               = bus.redirect_pc;
            if (bus.redirect_pc[0]) begin
                state_next        = HALT;
                trap_pending_next = 1'b1;
            end else begin
                state_next        = RUN;
                trap_pending_next = 1'b0;
            end
`else
            // Halfword alignment to match the ROM's address[9:1] indexing.
            pc_next = bus.redirect_pc & ~32'd1;
`endif
        end
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
        else if (state == HALT) begin
            // PC is frozen in HALT; only the IF/ID entry changes.
            if (bus.flush) begin
                entry_valid_next      = 1'b0;
                entry_instr_next      = NOP_INSTR;
                entry_misaligned_next = 1'b0;
            end else if (!bus.stall) begin
                if (trap_pending) begin
                    entry_valid_next      = 1'b1;
                    entry_misaligned_next = 1'b1;
                    entry_pc_next         = pc;
                    entry_pc_plus4_next   = pc_plus4;
                    entry_instr_next      = NOP_INSTR;
                    trap_pending_next     = 1'b0;
                end else begin
                    entry_valid_next      = 1'b0;
                    entry_instr_next      = NOP_INSTR;
                    entry_misaligned_next = 1'b0;
                end
            end
        end
`endif
        else if (bus.flush) begin
            entry_valid_next = 1'b0;
            entry_instr_next = NOP_INSTR;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            entry_misaligned_next = 1'b0;
`endif
            if (!bus.stall) begin
                pc_next = pc_plus4;
            end
        end else if (!bus.stall) begin
            entry_valid_next    = 1'b1;
            entry_pc_next       = pc;
            entry_pc_plus4_next = pc_plus4;
            entry_instr_next    = bus.rom_data;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            entry_misaligned_next = 1'b0;
`endif
            pc_next = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= RUN;
            pc             <= RESET_PC;
            entry_valid    <= 1'b0;
            entry_pc       <= 32'd0;
            entry_pc_plus4 <= 32'd4;
            entry_instr    <= NOP_INSTR;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            entry_misaligned <= 1'b0;
            trap_pending     <= 1'b0;
`endif
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            entry_valid    <= entry_valid_next;
            entry_pc       <= entry_pc_next;
            entry_pc_plus4 <= entry_pc_plus4_next;
            entry_instr    <= entry_instr_next;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            entry_misaligned <= entry_misaligned_next;
            trap_pending     <= trap_pending_next;
`endif
        end
    end

    assign bus.rom_address    = pc;
    assign bus.if_valid       = entry_valid;
    assign bus.if_pc          = entry_pc;
    assign bus.if_pc_plus4    = entry_pc_plus4;
    assign bus.if_instruction = entry_instr;
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
    assign bus.if_misaligned  = entry_misaligned;
`else
    assign bus.if_misaligned  = 1'b0;
`endif
    assign debug_state        = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Randomized plus directed stimulus for instruction_fetch. Every cycle the
//   driver applies inputs, a reference model predicts the post-edge outputs
//   and pushes them into exp_q; a monitor pops and compares after each edge.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic        misaligned;
        logic        pc_known;     // if_pc / if_pc_plus4 are defined
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic [31:0] rom_address;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic debug_state;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .debug_state (debug_state)
    );

    // Instruction ROM: word selected by address[9:1].
    logic [31:0] rom [512];
    assign bus.rom_data = rom[bus.rom_address[9:1]];

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_pending;
    exp_t        m_entry;
    exp_t        exp_q[$];

    int compared   = 0;
    int mismatched = 0;

    function automatic exp_t bubble(input exp_t cur);
        exp_t b;
        b            = cur;
        b.valid      = 1'b0;
        b.misaligned = 1'b0;
        b.pc_known   = 1'b0;
        b.instr      = NOP;
        return b;
    endfunction

    task automatic model_step(input logic r, input logic st, input logic fl,
                              input logic rv, input logic [31:0] rpc);
        if (r) begin
            m_pc      = 32'd0;
            m_halt    = 1'b0;
            m_pending = 1'b0;
            m_entry   = '{valid: 1'b0, misaligned: 1'b0, pc_known: 1'b1,
                          pc: 32'd0, pc_plus4: 32'd4, instr: NOP,
                          rom_address: 32'd0};
        end else if (rv) begin
            m_entry = bubble(m_entry);
`ifdef INSTRUCTION_FETCH_MISALIGN_TRAP_EN
            m_pc      = rpc;
            m_halt    = rpc[0];
            m_pending = rpc[0];
`else
            m_pc = {rpc[31:1], 1'b0};
`endif
        end else if (m_halt) begin
            if (fl) begin
                m_entry = bubble(m_entry);
            end else if (!st) begin
                if (m_pending) begin
                    m_entry = '{valid: 1'b1, misaligned: 1'b1, pc_known: 1'b1,
                                pc: m_pc, pc_plus4: m_pc + 32'd4, instr: NOP,
                                rom_address: 32'd0};
                    m_pending = 1'b0;
                end else begin
                    m_entry = bubble(m_entry);
                end
            end
        end else if (fl) begin
            m_entry = bubble(m_entry);
            if (!st) m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_entry = '{valid: 1'b1, misaligned: 1'b0, pc_known: 1'b1,
                        pc: m_pc, pc_plus4: m_pc + 32'd4,
                        instr: rom[m_pc[9:1]], rom_address: 32'd0};
            m_pc = m_pc + 32'd4;
        end
        m_entry.rom_address = m_pc;
        exp_q.push_back(m_entry);
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic r, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset              = r;
        bus.stall          = st;
        bus.flush          = fl;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        model_step(r, st, fl, rv, rpc);
        @(posedge clk);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("if_valid", {31'd0, bus.if_valid}, {31'd0, e.valid});
            chk("if_misaligned", {31'd0, bus.if_misaligned}, {31'd0, e.misaligned});
            chk("if_instruction", bus.if_instruction, e.instr);
            chk("rom_address", bus.rom_address, e.rom_address);
            if (e.pc_known) begin
                chk("if_pc", bus.if_pc, e.pc);
                chk("if_pc_plus4", bus.if_pc_plus4, e.pc_plus4);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rpc;
        int          sel;

        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        m_pc      = 32'd0;
        m_halt    = 1'b0;
        m_pending = 1'b0;
        m_entry   = '0;
        for (int i = 0; i < 512; i++) begin
            rom[i] = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
        end

        // Reset, then four free-running fetches.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        // Stall for three cycles holding entry pc=4 with pc=8.
        cyc(0, 0, 0, 1, 32'h0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Redirect under stall.
        cyc(0, 1, 0, 1, 32'h40);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Flush alone at pc=12.
        cyc(0, 0, 0, 1, 32'hC);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Flush together with stall: pc holds.
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // PC wrap.
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // Reset together with a redirect.
        cyc(1, 0, 0, 1, 32'h80);
        cyc(0, 0, 0, 0, 0);
        // Odd redirect target.
        cyc(0, 0, 0, 1, 32'h21);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 32'h0);
        repeat (2) cyc(0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                1:       rpc = 32'hFFFF_FFFC;
                2:       rpc = {22'd0, 9'($urandom_range(0, 511)), 1'b1};
                default: rpc = $urandom & ~32'd3;
            endcase
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                rpc);
        end

        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the single-issue RV32 pipeline.
- Owns the program counter and drives the address of the combinational instruction ROM, which returns the 32-bit word selected by address[9:1].
- Registers the PC and the returned word into the IF/ID pipeline register consumed by decode.
- Handles stall, flush and branch/jump redirect from later stages.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, word placed in if_instruction for bubbles (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID register (decode not ready / hazard).
- flush  input  1  squash the IF/ID entry (bubble).
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_pc  input  32  redirect target.
- rom_address  output  32  address to the instruction ROM, equal to pc (combinational).
- rom_data  input  32  instruction word from the ROM, same cycle.
- if_valid  output  1  IF/ID entry holds a real instruction.
- if_pc  output  32  PC of the IF/ID entry.
- if_pc_plus4  output  32  if_pc + 4 (link value for jal/jalr).
- if_instruction  output  32  instruction of the IF/ID entry.
- if_misaligned  output  1  entry is a misaligned-fetch trap (optional feature; otherwise constant 0).

Behaviour:
- Internal pc register, 32 bits. rom_address = pc, with no register between them.
- Reset (synchronous, highest priority) sets:
  - pc = RESET_PC
  - if_valid = 0, if_pc = 0, if_pc_plus4 = 4, if_instruction = NOP_INSTR, if_misaligned = 0
  - state = RUN
- Reset asserted mid-stream discards any pending redirect or stall effect in that cycle.
- Per-edge priority when not in reset: redirect_valid > flush > stall > normal.
  - redirect_valid: pc <= redirect_pc; IF/ID <= bubble (valid 0, NOP_INSTR). Overrides stall, so the redirect is never lost.
  - flush (no redirect): IF/ID <= bubble; pc <= pc + 4 unless stall is also high, in which case pc holds.
  - stall only: pc and the IF/ID register hold all values.
  - normal: IF/ID <= {valid 1, pc, pc+4, rom_data}; pc <= pc + 4.
- Arithmetic: pc + 4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0 with no flag.
- Addresses beyond the ROM window (pc[31:10] != 0) are not checked. Whatever rom_data returns (0 for unpopulated entries) is passed through with valid 1.
- Latency: an instruction at PC p appears on if_* one edge after pc == p with stall low. After a redirect, the first target instruction appears two edges later (one bubble).
- State machine, 2 states:
  - RUN: behaviour as above.
  - HALT: only used with the optional feature; otherwise unreachable.
- Without the feature, redirect_pc[0] is cleared when loaded, giving halfword alignment to match the ROM's address[9:1] indexing.

Optional Feature:
- Macro: INSTRUCTION_FETCH_MISALIGN_TRAP_EN.
- When defined, a redirect with redirect_pc[0] == 1 does the following:
  - pc <= redirect_pc unmodified; state <= HALT.
  - On the next non-stalled edge, IF/ID <= {valid 1, if_misaligned 1, pc, pc+4, NOP_INSTR}.
  - The stage then stays in HALT with if_valid 0 and pc frozen until the next redirect_valid with bit0 == 0, which returns it to RUN, or until reset.
  - flush in HALT only clears the IF/ID entry.
- When undefined: no HALT logic, bit0 is cleared as above, and if_misaligned is tied to 0.

Test Plan:
- Reset, then 4 free-running cycles with ROM words W0..W3 at 0,4,8,12 -> if_pc 0,4,8,12 on successive edges, if_valid 1, if_instruction W0..W3, if_pc_plus4 = if_pc+4; rom_address 16 after the 4th edge.
- Stall high for 3 cycles at pc=8 -> pc, if_pc=4 and if_instruction held for 3 cycles; resumes with if_pc=8.
- redirect_valid with redirect_pc=32'h40 while stall=1 -> next edge if_valid 0, if_instruction 32'h00000013, rom_address 32'h40; following edge if_pc 32'h40.
- flush alone at pc=12 -> bubble entry; pc advances to 16; next entry if_pc 16. pc preloaded to 32'hFFFFFFFC via redirect -> following PC is 0.
- Reset asserted together with redirect_valid (redirect_pc=32'h80) -> pc = RESET_PC, if_valid 0.
- With INSTRUCTION_FETCH_MISALIGN_TRAP_EN: redirect to 32'h21 -> one entry with if_misaligned 1, if_pc 32'h21, then if_valid 0 until a redirect to 32'h0 resumes fetch at 0. Without the macro: same redirect -> fetch at 32'h20, if_misaligned 0.
